// File: rtl/block_dispatcher_pkg.sv
// Shared state encodings and block arithmetic for the block dispatcher.
package block_dispatcher_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;

    localparam logic [1:0] C_FREE  = 2'd0;
    localparam logic [1:0] C_RESET = 2'd1;
    localparam logic [1:0] C_RUN   = 2'd2;

    // Ceil-division kept in 9 bits so a 255-thread launch cannot overflow.
    function automatic logic [8:0] blocks_for(input logic [7:0] tc, input logic [8:0] tpb);
        logic [8:0] sum;
        sum = {1'b0, tc} + tpb - 9'd1;
        return sum / tpb;
    endfunction

endpackage

// File: rtl/block_dispatcher_if.sv
// Launch-control and core-array signals between the dispatcher and its surroundings.
interface block_dispatcher_if #(
    parameter int NUM_CORES     = 2,
    parameter int BLOCK_ID_BITS = 8
);
    logic                              start;
    logic [7:0]                        thread_count;
    logic                              done;
    logic [NUM_CORES-1:0]              core_reset;
    logic [NUM_CORES-1:0]              core_start;
    logic [NUM_CORES*BLOCK_ID_BITS-1:0] core_block_id;
    logic [NUM_CORES*8-1:0]            core_thread_count;
    logic [NUM_CORES-1:0]              core_done;

    modport slave (
        input  start, thread_count, core_done,
        output done, core_reset, core_start, core_block_id, core_thread_count
    );

    modport master (
        output start, thread_count, core_done,
        input  done, core_reset, core_start, core_block_id, core_thread_count
    );
endinterface

// File: rtl/block_dispatcher_dispatch_slot.sv
// One core slot: resets the core for a cycle, then holds start until the core reports done.
module dispatch_slot
    import block_dispatcher_pkg::*;
#(
    parameter int BLOCK_ID_BITS = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     dispatch,
    input  logic [BLOCK_ID_BITS-1:0] block_id,
    input  logic [7:0]               thread_count,
    input  logic                     core_done,
    output logic                     core_reset,
    output logic                     core_start,
    output logic [BLOCK_ID_BITS-1:0] core_block_id,
    output logic [7:0]               core_thread_count,
    output logic                     free,
    output logic                     retire
);

    logic [1:0] state;

    assign free   = (state == C_FREE);
    // done only counts once the core has actually been started
    assign retire = (state == C_RUN) && core_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= C_FREE;
            core_reset        <= 1'b0;
            core_start        <= 1'b0;
            core_block_id     <= '0;
            core_thread_count <= '0;
        end else begin
            case (state)
                C_FREE: begin
                    if (dispatch) begin
                        state             <= C_RESET;
                        core_reset        <= 1'b1;
                        core_block_id     <= block_id;
                        core_thread_count <= thread_count;
                    end
                end
                C_RESET: begin
                    state      <= C_RUN;
                    core_reset <= 1'b0;
                    core_start <= 1'b1;
                end
                C_RUN: begin
                    if (core_done) begin
                        state      <= C_FREE;
                        core_start <= 1'b0;
                    end
                end
                default: begin
                    state      <= C_FREE;
                    core_reset <= 1'b0;
                    core_start <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/block_dispatcher.sv
// Kernel launch scheduler: splits thread_count into blocks and feeds them to idle cores.
module block_dispatcher
    import block_dispatcher_pkg::*;
#(
    parameter int NUM_CORES         = 2,
    parameter int THREADS_PER_BLOCK = 4,
    parameter int BLOCK_ID_BITS     = 8
) (
    input logic               clk,
    input logic               reset,
    block_dispatcher_if.slave bus
);

    logic [1:0]                         state;
    logic [7:0]                         tc_q;
    logic [BLOCK_ID_BITS-1:0]           total_blocks;
    logic [BLOCK_ID_BITS-1:0]           dispatched;
    logic [BLOCK_ID_BITS-1:0]           retired;
    logic [BLOCK_ID_BITS-1:0]           retire_cnt;
    logic [BLOCK_ID_BITS-1:0]           retired_next;
    logic [NUM_CORES-1:0]               free;
    logic [NUM_CORES-1:0]               retire;
    logic [NUM_CORES-1:0]               dispatch;
    logic                               dispatch_any;
    logic [15:0]                        base;
    logic [15:0]                        remain;
    logic [7:0]                         blk_count;
    logic [NUM_CORES-1:0]               core_reset_v;
    logic [NUM_CORES-1:0]               core_start_v;
    logic [NUM_CORES*BLOCK_ID_BITS-1:0] core_block_id_v;
    logic [NUM_CORES*8-1:0]             core_thread_count_v;

    assign bus.done              = (state == FINISH);
    assign bus.core_reset        = core_reset_v;
    assign bus.core_start        = core_start_v;
    assign bus.core_block_id     = core_block_id_v;
    assign bus.core_thread_count = core_thread_count_v;

    // Lowest-index free core wins; at most one dispatch per cycle.
    always_comb begin
        dispatch     = '0;
        dispatch_any = 1'b0;
        if (state == RUN && dispatched < total_blocks) begin
            for (int k = 0; k < NUM_CORES; k++) begin
                if (free[k] && !dispatch_any) begin
                    dispatch[k]  = 1'b1;
                    dispatch_any = 1'b1;
                end
            end
        end
    end

    always_comb begin
        retire_cnt = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            retire_cnt = retire_cnt + BLOCK_ID_BITS'(retire[k]);
        end
    end

    assign retired_next = retired + retire_cnt;

    // Last block may be partial; the others carry a full THREADS_PER_BLOCK.
    assign base      = 16'(dispatched) * 16'(THREADS_PER_BLOCK);
    assign remain    = 16'(tc_q) - base;
    assign blk_count = (remain > 16'(THREADS_PER_BLOCK)) ? 8'(THREADS_PER_BLOCK) : remain[7:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            tc_q         <= '0;
            total_blocks <= '0;
            dispatched   <= '0;
            retired      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        tc_q         <= bus.thread_count;
                        total_blocks <= BLOCK_ID_BITS'(blocks_for(bus.thread_count,
                                                                  9'(THREADS_PER_BLOCK)));
                        dispatched   <= '0;
                        retired      <= '0;
                        state        <= RUN;
                    end
                end
                RUN: begin
                    if (dispatch_any) dispatched <= dispatched + 1'b1;
                    retired <= retired_next;
                    if (retired_next == total_blocks) state <= FINISH;
                end
                FINISH: begin
                    if (!bus.start) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < NUM_CORES; k++) begin : g_slot
        dispatch_slot #(
            .BLOCK_ID_BITS(BLOCK_ID_BITS)
        ) u_slot (
            .clk              (clk),
            .reset            (reset),
            .dispatch         (dispatch[k]),
            .block_id         (dispatched),
            .thread_count     (blk_count),
            .core_done        (bus.core_done[k]),
            .core_reset       (core_reset_v[k]),
            .core_start       (core_start_v[k]),
            .core_block_id    (core_block_id_v[k*BLOCK_ID_BITS +: BLOCK_ID_BITS]),
            .core_thread_count(core_thread_count_v[k*8 +: 8]),
            .free             (free[k]),
            .retire           (retire[k])
        );
    end

endmodule

// File: tb/tb_block_dispatcher.sv
// Directed bench for block_dispatcher with two cores and four threads per block.
module tb_block_dispatcher;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    block_dispatcher_if #(.NUM_CORES(2), .BLOCK_ID_BITS(8)) bus ();

    block_dispatcher #(
        .NUM_CORES(2),
        .THREADS_PER_BLOCK(4),
        .BLOCK_ID_BITS(8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset            = 1'b1;
        bus.start        = 1'b0;
        bus.thread_count = 8'd0;
        bus.core_done    = 2'b00;
        step(2);
        check("rst_done",  32'(bus.done), 32'h0);
        check("rst_creset", 32'(bus.core_reset), 32'h0);
        check("rst_cstart", 32'(bus.core_start), 32'h0);
        check("rst_id",    32'(bus.core_block_id), 32'h0);
        check("rst_cnt",   32'(bus.core_thread_count), 32'h0);
        reset = 1'b0;
        step();

        // 8 threads: two full blocks, one per core
        bus.start = 1'b1; bus.thread_count = 8'd8;
        step();
        check("t1_e1_creset", 32'(bus.core_reset), 32'h0);
        check("t1_e1_cstart", 32'(bus.core_start), 32'h0);
        step();
        check("t1_e2_creset", 32'(bus.core_reset), 32'h1);
        check("t1_e2_cstart", 32'(bus.core_start), 32'h0);
        check("t1_e2_id",     32'(bus.core_block_id), 32'h0000);
        check("t1_e2_cnt",    32'(bus.core_thread_count[7:0]), 32'h4);
        step();
        check("t1_e3_creset", 32'(bus.core_reset), 32'h2);
        check("t1_e3_cstart", 32'(bus.core_start), 32'h1);
        check("t1_e3_id",     32'(bus.core_block_id), 32'h0100);
        check("t1_e3_cnt",    32'(bus.core_thread_count), 32'h0404);
        step();
        check("t1_e4_creset", 32'(bus.core_reset), 32'h0);
        check("t1_e4_cstart", 32'(bus.core_start), 32'h3);
        step(6);
        check("t1_wait_cstart", 32'(bus.core_start), 32'h3);
        check("t1_wait_done",   32'(bus.done), 32'h0);
        bus.core_done = 2'b11;
        step();
        check("t1_done",        32'(bus.done), 32'h1);
        check("t1_fin_cstart",  32'(bus.core_start), 32'h0);
        bus.core_done = 2'b00;
        step(2);
        check("t1_hold_done",   32'(bus.done), 32'h1);
        check("t1_no_redisp",   32'(bus.core_reset), 32'h0);
        bus.start = 1'b0;
        step();
        check("t1_clr_done",    32'(bus.done), 32'h0);

        // 10 threads: block 2 is partial and lands on whichever core frees first
        bus.start = 1'b1; bus.thread_count = 8'd10;
        step(2);
        check("t2_e2_creset", 32'(bus.core_reset), 32'h1);
        step();
        check("t2_e3_creset", 32'(bus.core_reset), 32'h2);
        check("t2_e3_id",     32'(bus.core_block_id), 32'h0100);
        step();
        check("t2_e4_cstart", 32'(bus.core_start), 32'h3);
        bus.start = 1'b0;
        step();
        check("t2_drop_done", 32'(bus.done), 32'h0);
        bus.start = 1'b1;
        step();
        check("t2_no_relaunch_creset", 32'(bus.core_reset), 32'h0);
        check("t2_no_relaunch_cstart", 32'(bus.core_start), 32'h3);
        bus.core_done = 2'b10;
        step();
        check("t2_c1_free_cstart", 32'(bus.core_start), 32'h1);
        bus.core_done = 2'b00;
        step();
        check("t2_b2_creset", 32'(bus.core_reset), 32'h2);
        check("t2_b2_id",     32'(bus.core_block_id), 32'h0200);
        check("t2_b2_cnt",    32'(bus.core_thread_count), 32'h0204);
        check("t2_b2_done",   32'(bus.done), 32'h0);
        step();
        check("t2_b2_cstart", 32'(bus.core_start), 32'h3);
        check("t2_b2_creset_end", 32'(bus.core_reset), 32'h0);
        bus.core_done = 2'b11;
        step();
        check("t2_done",        32'(bus.done), 32'h1);
        check("t2_fin_cstart",  32'(bus.core_start), 32'h0);
        bus.core_done = 2'b00; bus.start = 1'b0;
        step();
        check("t2_clr_done", 32'(bus.done), 32'h0);

        // zero threads: finish without touching the cores
        bus.start = 1'b1; bus.thread_count = 8'd0;
        step();
        check("t3_e1_done", 32'(bus.done), 32'h0);
        step();
        check("t3_done",    32'(bus.done), 32'h1);
        check("t3_creset",  32'(bus.core_reset), 32'h0);
        check("t3_cstart",  32'(bus.core_start), 32'h0);
        bus.start = 1'b0;
        step();
        check("t3_clr_done", 32'(bus.done), 32'h0);

        // 16 threads with spurious core_done[1] while slot 1 is free then in reset
        bus.start = 1'b1; bus.thread_count = 8'd16; bus.core_done = 2'b10;
        step();
        check("t4_e1_done",   32'(bus.done), 32'h0);
        step();
        check("t4_e2_creset", 32'(bus.core_reset), 32'h1);
        check("t4_e2_done",   32'(bus.done), 32'h0);
        step();
        check("t4_e3_creset", 32'(bus.core_reset), 32'h2);
        step();
        check("t4_e4_cstart", 32'(bus.core_start), 32'h3);
        check("t4_e4_done",   32'(bus.done), 32'h0);
        bus.core_done = 2'b00;
        step();
        check("t4_idle_cstart", 32'(bus.core_start), 32'h3);
        bus.core_done = 2'b11;
        step();
        check("t4_both_free_cstart", 32'(bus.core_start), 32'h0);
        check("t4_both_free_done",   32'(bus.done), 32'h0);
        bus.core_done = 2'b00;
        step();
        check("t4_b2_creset", 32'(bus.core_reset), 32'h1);
        check("t4_b2_id",     32'(bus.core_block_id), 32'h0102);
        step();
        check("t4_b3_creset", 32'(bus.core_reset), 32'h2);
        check("t4_b3_id",     32'(bus.core_block_id), 32'h0302);
        check("t4_b3_cstart", 32'(bus.core_start), 32'h1);
        step();
        check("t4_run_cstart", 32'(bus.core_start), 32'h3);
        check("t4_run_done",   32'(bus.done), 32'h0);
        bus.core_done = 2'b11;
        step();
        check("t4_done", 32'(bus.done), 32'h1);
        bus.core_done = 2'b00; bus.start = 1'b0;
        step();
        check("t4_clr_done", 32'(bus.done), 32'h0);

        // asynchronous reset mid-run, then a fresh single-block launch
        bus.start = 1'b1; bus.thread_count = 8'd8;
        step(4);
        check("t5_pre_cstart", 32'(bus.core_start), 32'h3);
        #2;
        reset = 1'b1; bus.start = 1'b0;
        #1;
        check("t5_async_cstart", 32'(bus.core_start), 32'h0);
        check("t5_async_creset", 32'(bus.core_reset), 32'h0);
        check("t5_async_id",     32'(bus.core_block_id), 32'h0);
        check("t5_async_cnt",    32'(bus.core_thread_count), 32'h0);
        check("t5_async_done",   32'(bus.done), 32'h0);
        step();
        reset = 1'b0;
        step();
        bus.start = 1'b1; bus.thread_count = 8'd4;
        step();
        check("t5_e1_creset", 32'(bus.core_reset), 32'h0);
        step();
        check("t5_e2_creset", 32'(bus.core_reset), 32'h1);
        check("t5_e2_id",     32'(bus.core_block_id), 32'h0000);
        check("t5_e2_cnt",    32'(bus.core_thread_count), 32'h0004);
        step();
        check("t5_e3_creset", 32'(bus.core_reset), 32'h0);
        check("t5_e3_cstart", 32'(bus.core_start), 32'h1);
        step();
        check("t5_e4_cstart", 32'(bus.core_start), 32'h1);
        check("t5_e4_creset", 32'(bus.core_reset), 32'h0);
        bus.core_done = 2'b01;
        step();
        check("t5_done",       32'(bus.done), 32'h1);
        check("t5_fin_cstart", 32'(bus.core_start), 32'h0);
        bus.core_done = 2'b00; bus.start = 1'b0;
        step();
        check("t5_clr_done", 32'(bus.done), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
